// File: rtl/colproc_pkg.sv
// Shared types and constants for the colour-processing write path.
//   PIX_PAIR_W   : width of a processed pixel pair {pix1, pix0}
//   ZBT_ADDR_W   : ZBT bank address width
//   H_TOTAL_LAST : last horizontal count of a line (wrap point)
//   V_TOTAL_LAST : last vertical count of a frame (wrap point)
//   wr_entry_t   : one queued ZBT write {addr, data}
//   wr_state_t   : writer FSM state
package colproc_pkg;

  localparam int PIX_PAIR_W   = 36;
  localparam int ZBT_ADDR_W   = 19;
  localparam int H_TOTAL_LAST = 1048;
  localparam int V_TOTAL_LAST = 805;

  typedef struct packed {
    logic [ZBT_ADDR_W-1:0] addr;
    logic [PIX_PAIR_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [0:0] {
    WR_IDLE  = 1'b0,
    WR_ISSUE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/proc_fifo.sv
// Synchronous FIFO of wr_entry_t with registered occupancy.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   push       : write wr_data (accepted when not full, or when popping)
//   pop        : consume the head (caller guarantees !empty)
//   wr_data    : entry to write
//   rd_data    : head entry (valid when !empty)
//   full/empty : status derived from the registered count
//   count      : occupancy after the last edge
// Handshake: an entry is transferred on push when the FIFO can accept it,
// and on pop when the FIFO is not empty; both may happen in one cycle,
// including when full (the popped slot is reused by the push).
module proc_fifo
  import colproc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  wr_entry_t                wr_data,
  output wr_entry_t                rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wr_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/proc_zbt_writer.sv
// Captures processed pixel pairs on every address change, queues them and
// drains them into ZBT bank 1 during arbiter-granted write slots. The ZBT
// takes data ZBT_LAT cycles after its address, so popped data travels down
// a delay line while the address goes out immediately.
// Optional feature macro: BLANK_SKIP_EN -- suppress capture while the
// forecast position (hcount_f, vcount_f) lies in blanking.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   hcount, vcount  : current raster position (used with BLANK_SKIP_EN)
//   two_proc_pixs   : processed pixel pair {pix1, pix0}
//   proc_pix_addr   : ZBT address of that pair
//   wr_slot         : bank 1 granted to this block this cycle
//   clr_overflow    : clears the sticky overflow flag
//   mem_we/mem_addr : ZBT write command (one cycle per write)
//   mem_write_data  : ZBT write data, ZBT_LAT cycles after mem_addr
//   fifo_count      : queue occupancy
//   overflow        : sticky, a pair was dropped on a full queue
module proc_zbt_writer
  import colproc_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ZBT_LAT  = 2,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [10:0]             hcount,
  input  logic [9:0]              vcount,
  input  logic [PIX_PAIR_W-1:0]   two_proc_pixs,
  input  logic [ZBT_ADDR_W-1:0]   proc_pix_addr,
  input  logic                    wr_slot,
  input  logic                    clr_overflow,
  output logic                    mem_we,
  output logic [ZBT_ADDR_W-1:0]   mem_addr,
  output logic [PIX_PAIR_W-1:0]   mem_write_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow
);

  logic [ZBT_ADDR_W-1:0] last_addr;
  logic                  capture_en;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  full;
  logic                  empty;
  wr_entry_t             head;
  wr_entry_t             new_entry;
  wr_state_t             wr_state;

  // Data delay line: stage k holds data popped k+1 edges ago.
  logic [PIX_PAIR_W-1:0] dpipe [ZBT_LAT];
  logic [ZBT_LAT-1:0]    vpipe;

`ifdef BLANK_SKIP_EN
  logic [10:0] hcount_f;
  logic [9:0]  vcount_f;

  // Same +8 forecast as the colour-processing stage; past the last
  // horizontal count the forecast restarts at 0 on the next line.
  always_comb begin
    hcount_f = hcount + 11'd8;
    vcount_f = vcount;
    if (32'(hcount) >= H_TOTAL_LAST) begin
      hcount_f = hcount - 11'(H_TOTAL_LAST);
      vcount_f = (32'(vcount) == V_TOTAL_LAST) ? '0 : vcount + 10'd1;
    end
  end

  assign capture_en = (32'(hcount_f) < H_ACTIVE) && (32'(vcount_f) < V_ACTIVE);
`else
  logic unused_blank;
  assign unused_blank = ^{hcount, vcount, 32'(H_ACTIVE), 32'(V_ACTIVE)};
  assign capture_en   = 1'b1;
`endif

  // A suppressed cycle leaves last_addr alone, so the same address can
  // still be captured once it is back in the active area.
  assign push      = (proc_pix_addr != last_addr) && capture_en;
  assign pop       = wr_slot && !empty;
  assign drop      = push && full && !pop;
  assign new_entry = '{addr: proc_pix_addr, data: two_proc_pixs};

  proc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (new_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // Capture and overflow. A dropped pair still updates last_addr: the
  // pixel is lost rather than retried.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr <= '1;
      overflow  <= 1'b0;
    end else begin
      if (push) last_addr <= proc_pix_addr;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Writer FSM: WR_ISSUE is the cycle in which a write command is on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (wr_state)
        WR_IDLE:  wr_state <= pop ? WR_ISSUE : WR_IDLE;
        WR_ISSUE: wr_state <= pop ? WR_ISSUE : WR_IDLE;
        default:  wr_state <= WR_IDLE;
      endcase
      mem_we <= pop;
      if (pop) mem_addr <= head.addr;
    end
  end

  // Data delay line; reset drops in-flight data so nothing emerges later.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpipe          <= '0;
      mem_write_data <= '0;
      for (int k = 0; k < ZBT_LAT; k++) dpipe[k] <= '0;
    end else begin
      vpipe[0] <= pop;
      dpipe[0] <= head.data;
      for (int k = 1; k < ZBT_LAT; k++) begin
        vpipe[k] <= vpipe[k-1];
        dpipe[k] <= dpipe[k-1];
      end
      if (vpipe[ZBT_LAT-1]) mem_write_data <= dpipe[ZBT_LAT-1];
    end
  end

endmodule

// File: tb/tb_proc_zbt_writer.sv
module tb_proc_zbt_writer;

  localparam int ZBT_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [35:0] two_proc_pixs;
  logic [18:0] proc_pix_addr;
  logic        wr_slot;
  logic        clr_overflow;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [35:0] mem_write_data;
  logic [2:0]  fifo_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected writes {addr, data} in order, plus data due times.
  logic [54:0] exp_q[$];
  int          pend_due[$];
  logic [35:0] pend_data[$];
  int          cyc    = 0;
  int          wr_cnt = 0;
  bit          mon_en = 1'b1;

  proc_zbt_writer #(.DEPTH(4), .ZBT_LAT(ZBT_LAT), .H_ACTIVE(1024), .V_ACTIVE(768)) dut (
    .clk            (clk),
    .reset          (reset),
    .hcount         (hcount),
    .vcount         (vcount),
    .two_proc_pixs  (two_proc_pixs),
    .proc_pix_addr  (proc_pix_addr),
    .wr_slot        (wr_slot),
    .clr_overflow   (clr_overflow),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor on the falling edge: every write command must match the next
  // expected entry, and its data must appear exactly ZBT_LAT cycles later.
  always @(negedge clk) begin
    if (reset) begin
      pend_due.delete();
      pend_data.delete();
    end else if (mon_en) begin
      cyc++;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        chk("wr_data", mem_write_data, pend_data[0]);
        void'(pend_due.pop_front());
        void'(pend_data.pop_front());
      end
      if (mem_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", 1, 0);
        end else begin
          chk("wr_addr", mem_addr, exp_q[0][54:36]);
          pend_due.push_back(cyc + ZBT_LAT);
          pend_data.push_back(exp_q[0][35:0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    proc_pix_addr = 19'h7FFFF;
    two_proc_pixs = '0;
    wr_slot       = 1'b0;
    clr_overflow  = 1'b0;
    hcount        = 11'd0;
    vcount        = 10'd0;
    step();
    step();
    reset = 1'b0;
    wr_cnt = 0;
  endtask

  task automatic put(input logic [18:0] a, input logic [35:0] d);
    proc_pix_addr = a;
    two_proc_pixs = d;
  endtask

  task automatic expect_wr(input logic [18:0] a, input logic [35:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || pend_due.size() != 0) && n < 60) begin
      step();
      n++;
    end
    chk(tag, (n < 60), 1);
    repeat (4) step();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_data",  mem_write_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf",   overflow, 0);

    // 1: three pairs, each held two cycles, slots always granted
    expect_wr(19'h10, 36'hAAAAAAAAA);
    expect_wr(19'h11, 36'h555555555);
    expect_wr(19'h12, 36'h123456789);
    wr_slot = 1'b1;
    put(19'h10, 36'hAAAAAAAAA); step();
    chk("t1_cnt_push", fifo_count, 1);
    step();
    chk("t1_we0", mem_we, 1);
    chk("t1_cnt_pop", fifo_count, 0);
    put(19'h11, 36'h555555555); step(); step();
    put(19'h12, 36'h123456789); step(); step();
    drain("t1_drain");
    chk("t1_writes", wr_cnt, 3);

    // 2: constant address for 20 cycles pushes once
    do_reset();
    begin
      int peak = 0;
      put(19'h100, 36'hF0F0F0F0F);
      for (int i = 0; i < 20; i++) begin
        step();
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      chk("t2_peak", peak, 1);
      chk("t2_cnt", fifo_count, 1);
    end
    expect_wr(19'h100, 36'hF0F0F0F0F);
    wr_slot = 1'b1;
    drain("t2_drain");
    chk("t2_writes", wr_cnt, 1);

    // 3: overflow, clear, then drain in order
    do_reset();
    for (int i = 0; i < 5; i++) begin
      put(19'h200 + 19'(i), 36'h000000100 + 36'(i));
      step();
    end
    chk("t3_cnt_full", fifo_count, 4);
    chk("t3_ovf_set", overflow, 1);
    chk("t3_no_we", mem_we, 0);
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    for (int i = 0; i < 4; i++) expect_wr(19'h200 + 19'(i), 36'h000000100 + 36'(i));
    wr_slot = 1'b1;
    drain("t3_drain");
    chk("t3_writes", wr_cnt, 4);
    chk("t3_cnt_end", fifo_count, 0);

    // drop and clear in the same cycle: the drop wins
    do_reset();
    for (int i = 0; i < 4; i++) begin put(19'h280 + 19'(i), 36'(i)); step(); end
    clr_overflow = 1'b1;
    put(19'h284, 36'h4); step();
    clr_overflow = 1'b0;
    chk("t3_drop_wins", overflow, 1);

    // 4: full + new address + slot in one cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put(19'h300 + 19'(i), 36'h000003000 + 36'(i));
      step();
    end
    chk("t4_cnt_full", fifo_count, 4);
    for (int i = 0; i < 5; i++) expect_wr(19'h300 + 19'(i), 36'h000003000 + 36'(i));
    wr_slot = 1'b1;
    put(19'h304, 36'h000003004); step();
    chk("t4_cnt_same", fifo_count, 4);
    chk("t4_ovf", overflow, 0);
    drain("t4_drain");
    chk("t4_writes", wr_cnt, 5);

    // 5: reset one cycle after mem_we aborts the pending data
    do_reset();
    mon_en = 1'b0;
    wr_slot = 1'b1;
    put(19'h400, 36'h987654321); step(); step();
    chk("t5_we", mem_we, 1);
    chk("t5_addr", mem_addr, 19'h400);
    reset = 1'b1;
    proc_pix_addr = 19'h7FFFF;
    step();
    chk("t5_rst_we", mem_we, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_data", mem_write_data, 0);
    chk("t5_rst_cnt", fifo_count, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_quiet_data", mem_write_data, 0);
      chk("t5_quiet_we", mem_we, 0);
    end
    mon_en = 1'b1;

`ifdef BLANK_SKIP_EN
    // 6: blanking suppresses capture
    do_reset();
    hcount = 11'd1020; vcount = 10'd5;
    put(19'h500, 36'h1); step();
    chk("t6_blank", fifo_count, 0);
    hcount = 11'd1048;
    put(19'h501, 36'h2); step();
    chk("t6_active", fifo_count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/proc_zbt_writer.md
Name: proc_zbt_writer

Overview:
- Stage directly downstream of the colour-processing block.
- Captures each new processed pixel pair (36 bits) and its 19-bit ZBT bank-1 address, and queues it in a small FIFO.
- Drains the FIFO into ZBT bank 1 during write slots granted by the memory arbiter.
- Handles the pipelined ZBT write, where data lags address by ZBT_LAT cycles.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- ZBT_LAT, 2: cycles from mem_we/mem_addr to mem_write_data.
- H_ACTIVE, 1024: active pixels per line (used only with BLANK_SKIP_EN).
- V_ACTIVE, 768: active lines (used only with BLANK_SKIP_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hcount  in  11  current horizontal count.
- vcount  in  10  current vertical count.
- two_proc_pixs  in  36  processed pixel pair, {pix1[17:0], pix0[17:0]}.
- proc_pix_addr  in  19  write address, {vcount_f, hcount_f[9:1]}.
- wr_slot  in  1  arbiter grants ZBT bank 1 to this block this cycle.
- clr_overflow  in  1  clears overflow.
- mem_we  out  1  ZBT write enable, active-high, one cycle per write.
- mem_addr  out  19  ZBT write address.
- mem_write_data  out  36  ZBT write data, ZBT_LAT cycles after its address.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a pair was dropped.

Behaviour:
- Reset is synchronous and active-high. Reset values: FIFO empty, last_addr = 19'h7FFFF, mem_we=0, mem_addr=0, mem_write_data=0, fifo_count=0, overflow=0, data pipeline cleared.
- Reset mid-operation aborts in-flight writes: mem_we=0 from the next edge, and no delayed data is emitted.
- Capture:
  - Each cycle, if proc_pix_addr != last_addr: push {proc_pix_addr, two_proc_pixs} and set last_addr = proc_pix_addr.
  - An unchanged address never pushes, so each address is written once per pass.
- Full:
  - A push while full with no pop that cycle drops the pair and sets overflow.
  - last_addr still updates, so there is no retry.
- Push and pop in the same cycle are both accepted, including when full; count is unchanged.
- Empty:
  - There is no bypass. A pair pushed in cycle N is poppable in N+1 at the earliest.
  - wr_slot while empty does nothing (mem_we=0).
- Drain:
  - If wr_slot && !empty at edge N, pop the head.
  - In cycle N+1: mem_we=1, mem_addr=A.
  - In cycle N+1+ZBT_LAT: mem_write_data=D.
  - Back-to-back slots give one write per cycle, with the data pipeline fully overlapped.
  - mem_addr holds its last value when mem_we=0. mem_write_data holds its last value between writes.
- Overflow:
  - overflow is cleared by clr_overflow.
  - A drop in the same cycle as clr_overflow wins: overflow=1.
- fifo_count is registered and reflects the state after the edge.
- All outputs are registered.
- last_addr compare is full 19-bit. Wrap from 805→0 is an ordinary address change.

Optional Feature:
- Macro: BLANK_SKIP_EN.
- Defined:
  - Computes the forecast counts hcount_f and vcount_f with the same +8 forecast and wrap at 1048/805.
  - Suppresses the push when hcount_f ≥ H_ACTIVE or vcount_f ≥ V_ACTIVE.
  - last_addr is not updated on a suppressed cycle.
- Undefined: hcount/vcount are unused and every address change pushes.

Decomposition:
- Package colproc_pkg:
  - PIX_PAIR_W=36, ZBT_ADDR_W=19, H_TOTAL_LAST=1048, V_TOTAL_LAST=805.
  - Typedef wr_entry_t = {addr[18:0], data[35:0]}.
- Sub-module proc_fifo: synchronous FIFO of wr_entry_t with push, pop, full, empty and count.
- Writer FSM, ZBT data delay line and capture logic stay in the top.

Test Plan:
1. Reset, then addresses 0x00010, 0x00011, 0x00012 with data 0xAAAAAAAAA, 0x555555555, 0x123456789 held 2 cycles each; wr_slot=1 -> exactly 3 writes, mem_we pulses with addr 0x10/0x11/0x12, data appears 2 cycles after each address.
2. Address held constant 20 cycles -> exactly one push; fifo_count peaks at 1.
3. wr_slot=0, 5 distinct addresses -> fifo_count=4, 5th dropped, overflow=1. Then clr_overflow -> overflow=0. Then wr_slot=1 -> 4 writes in order.
4. FIFO full with a simultaneous new address and wr_slot -> push accepted, count stays 4, overflow stays 0.
5. Reset asserted one cycle after mem_we -> no mem_write_data change afterwards; all outputs 0.
6. BLANK_SKIP_EN, hcount=1020 (hcount_f=1028) with a new address -> no push. hcount=1048 (hcount_f=0), vcount=5 -> push.
